// File: rtl/associate_trainer.sv
// Training sequencer for the associate unit: EPOCHS learning passes over a stored table, then one scored pass.
// Per sample: at least 4 cycles in training and 2 in evaluation; every channel waits on its partner with valid and data held.
module associate_trainer #(
  parameter int unsigned N         = 2,
  parameter int unsigned ARG_WIDTH = 8,
  parameter int unsigned RES_WIDTH = 16,
  parameter int unsigned ERR_WIDTH = 16,
  parameter int unsigned FBK_WIDTH = 16,
  parameter int unsigned SAMPLES   = 4,
  parameter int unsigned EPOCHS    = 25,
  parameter logic [RES_WIDTH-1:0] ACT_HI = 'h00ff,
  localparam int unsigned AW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1,
  localparam int unsigned MW = $clog2(SAMPLES + 1),
  localparam int unsigned EW = (EPOCHS > 1) ? $clog2(EPOCHS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_en,
  input  logic [AW-1:0]            ld_addr,
  input  logic [N*ARG_WIDTH-1:0]   ld_arg,
  input  logic [RES_WIDTH-1:0]     ld_tgt,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [MW-1:0]            mismatches,
  output logic                     en,
  output logic                     arg_valid,
  input  logic                     arg_ready,
  output logic [N*ARG_WIDTH-1:0]   arg_data,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [RES_WIDTH-1:0]     res_data,
  output logic                     err_valid,
  input  logic                     err_ready,
  output logic [ERR_WIDTH-1:0]     err_data,
  input  logic                     fbk_valid,
  output logic                     fbk_ready,
  input  logic [N*FBK_WIDTH-1:0]   fbk_data
);

  localparam int unsigned LAST_EP = (EPOCHS > 0) ? EPOCHS - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRN_ARG,
    S_TRN_RES,
    S_TRN_ERR,
    S_TRN_FBK,
    S_EVL_ARG,
    S_EVL_RES,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic [EW-1:0]            epoch_q, epoch_d;
  logic [MW-1:0]            mismatches_q, mismatches_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic                     en_q, en_d;
  logic                     arg_valid_q, arg_valid_d;
  logic [N*ARG_WIDTH-1:0]   arg_data_q, arg_data_d;
  logic                     res_ready_q, res_ready_d;
  logic                     err_valid_q, err_valid_d;
  logic [ERR_WIDTH-1:0]     err_data_q, err_data_d;
  logic                     fbk_ready_q, fbk_ready_d;

  logic [N*ARG_WIDTH-1:0]   tbl_arg [SAMPLES];
  logic [RES_WIDTH-1:0]     tbl_tgt [SAMPLES];

  logic                     ld_ok;
  logic                     arg_xfer, res_xfer, err_xfer, fbk_xfer;
  logic                     last_idx, last_epoch;
  logic                     load_arg;
  logic [RES_WIDTH-1:0]     act;
  logic [ERR_WIDTH-1:0]     tgt_ext, act_ext, err_calc;
  logic [N*ARG_WIDTH-1:0]   next_arg;
  logic                     unused_fbk;

  // The feedback vector only completes the handshake; its contents are not needed here.
  assign unused_fbk = ^fbk_data;

  assign ld_ok    = ld_en && !busy_q && (32'(ld_addr) < SAMPLES);
  assign arg_xfer = arg_valid_q && arg_ready;
  assign res_xfer = res_ready_q && res_valid;
  assign err_xfer = err_valid_q && err_ready;
  assign fbk_xfer = fbk_ready_q && fbk_valid;

  assign last_idx   = (idx_q == AW'(SAMPLES - 1));
  assign last_epoch = (epoch_q == EW'(LAST_EP));

  // Threshold the response, then signed error against the stored target (wraps, no saturation).
  assign act      = res_data[RES_WIDTH-1] ? '0 : ACT_HI;
  assign tgt_ext  = ERR_WIDTH'($signed(tbl_tgt[idx_q]));
  assign act_ext  = ERR_WIDTH'($signed(act));
  assign err_calc = tgt_ext - act_ext;

  always_ff @(posedge clk) begin
    if (ld_ok) begin
      tbl_arg[ld_addr] <= ld_arg;
      tbl_tgt[ld_addr] <= ld_tgt;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    epoch_d      = epoch_q;
    mismatches_d = mismatches_q;
    err_data_d   = err_data_q;
    load_arg     = 1'b0;
    next_arg     = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = (EPOCHS == 0) ? S_EVL_ARG : S_TRN_ARG;
          idx_d        = '0;
          epoch_d      = '0;
          mismatches_d = '0;
          load_arg     = 1'b1;
        end
      end
      S_TRN_ARG: if (arg_xfer) state_d = S_TRN_RES;
      S_TRN_RES: begin
        if (res_xfer) begin
          err_data_d = err_calc;
          state_d    = S_TRN_ERR;
        end
      end
      S_TRN_ERR: if (err_xfer) state_d = S_TRN_FBK;
      S_TRN_FBK: begin
        if (fbk_xfer) begin
          load_arg = 1'b1;
          if (last_idx) begin
            idx_d = '0;
            if (last_epoch) begin
              state_d = S_EVL_ARG;
            end else begin
              epoch_d = epoch_q + EW'(1);
              state_d = S_TRN_ARG;
            end
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_TRN_ARG;
          end
        end
      end
      S_EVL_ARG: if (arg_xfer) state_d = S_EVL_RES;
      S_EVL_RES: begin
        if (res_xfer) begin
          if (err_calc != '0) mismatches_d = mismatches_q + MW'(1);
          if (last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d    = idx_q + AW'(1);
            state_d  = S_EVL_ARG;
            load_arg = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A load accepted in the same cycle as start must be seen by the first arg.
    if (ld_ok && (ld_addr == idx_d)) next_arg = ld_arg;
    else                             next_arg = tbl_arg[idx_d];
    arg_data_d = load_arg ? next_arg : arg_data_q;

    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    pass_d      = (state_d == S_DONE) && (mismatches_d == '0);
    en_d        = (state_d == S_TRN_ARG) || (state_d == S_TRN_RES) ||
                  (state_d == S_TRN_ERR) || (state_d == S_TRN_FBK);
    arg_valid_d = (state_d == S_TRN_ARG) || (state_d == S_EVL_ARG);
    res_ready_d = (state_d == S_TRN_RES) || (state_d == S_EVL_RES);
    err_valid_d = (state_d == S_TRN_ERR);
    fbk_ready_d = (state_d == S_TRN_FBK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      epoch_q      <= '0;
      mismatches_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      en_q         <= 1'b0;
      arg_valid_q  <= 1'b0;
      arg_data_q   <= '0;
      res_ready_q  <= 1'b0;
      err_valid_q  <= 1'b0;
      err_data_q   <= '0;
      fbk_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      epoch_q      <= epoch_d;
      mismatches_q <= mismatches_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      en_q         <= en_d;
      arg_valid_q  <= arg_valid_d;
      arg_data_q   <= arg_data_d;
      res_ready_q  <= res_ready_d;
      err_valid_q  <= err_valid_d;
      err_data_q   <= err_data_d;
      fbk_ready_q  <= fbk_ready_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign mismatches = mismatches_q;
  assign en         = en_q;
  assign arg_valid  = arg_valid_q;
  assign arg_data   = arg_data_q;
  assign res_ready  = res_ready_q;
  assign err_valid  = err_valid_q;
  assign err_data   = err_data_q;
  assign fbk_ready  = fbk_ready_q;

endmodule

// File: tb/tb_associate_trainer.sv
// Directed bench for associate_trainer: a small perceptron plays the associate unit;
// a second instance with EPOCHS=0 covers the evaluate-only configuration.
`timescale 1ns/1ps
module tb_associate_trainer;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        ld_en = 1'b0;
  logic [1:0]  ld_addr = '0;
  logic [15:0] ld_arg = '0;
  logic [15:0] ld_tgt = '0;
  logic        start1 = 1'b0, start0 = 1'b0;
  logic        arg_ready = 1'b0, res_valid = 1'b0, err_ready = 1'b0, fbk_valid = 1'b0;
  logic [15:0] res_data = '0;
  logic [31:0] fbk_data = '0;

  logic        busy1, done1, pass1, en1, av1, rr1, ev1, fr1;
  logic [2:0]  mm1;
  logic [15:0] ad1, ed1;
  logic        busy0, done0, pass0, en0, av0, rr0, ev0, fr0;
  logic [2:0]  mm0;
  logic [15:0] ad0, ed0;

  logic        sel = 1'b1;
  logic        busy_m, done_m, pass_m, en_m, av_m, rr_m, ev_m, fr_m;
  logic [2:0]  mm_m;
  logic [15:0] ad_m, ed_m;

  associate_trainer #(.EPOCHS(25)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_arg(ld_arg), .ld_tgt(ld_tgt),
    .start(start1), .busy(busy1), .done(done1), .pass(pass1), .mismatches(mm1), .en(en1),
    .arg_valid(av1), .arg_ready(arg_ready), .arg_data(ad1),
    .res_valid(res_valid), .res_ready(rr1), .res_data(res_data),
    .err_valid(ev1), .err_ready(err_ready), .err_data(ed1),
    .fbk_valid(fbk_valid), .fbk_ready(fr1), .fbk_data(fbk_data)
  );

  associate_trainer #(.EPOCHS(0)) dut0 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_arg(ld_arg), .ld_tgt(ld_tgt),
    .start(start0), .busy(busy0), .done(done0), .pass(pass0), .mismatches(mm0), .en(en0),
    .arg_valid(av0), .arg_ready(arg_ready), .arg_data(ad0),
    .res_valid(res_valid), .res_ready(rr0), .res_data(res_data),
    .err_valid(ev0), .err_ready(err_ready), .err_data(ed0),
    .fbk_valid(fbk_valid), .fbk_ready(fr0), .fbk_data(fbk_data)
  );

  assign busy_m = sel ? busy1 : busy0;
  assign done_m = sel ? done1 : done0;
  assign pass_m = sel ? pass1 : pass0;
  assign en_m   = sel ? en1   : en0;
  assign av_m   = sel ? av1   : av0;
  assign rr_m   = sel ? rr1   : rr0;
  assign ev_m   = sel ? ev1   : ev0;
  assign fr_m   = sel ? fr1   : fr0;
  assign mm_m   = sel ? mm1   : mm0;
  assign ad_m   = sel ? ad1   : ad0;
  assign ed_m   = sel ? ed1   : ed0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Associate model state and scoreboard counters
  logic [15:0] tb_arg [S];
  logic [15:0] tb_tgt [S];
  int  max_st = 0;
  bit  err_hold = 1'b0;
  bit  res_neg = 1'b0;
  int  w0, w1, bias, x0, x1;
  int  arg_cnt, res_cnt, err_cnt, fbk_cnt, en0_cnt, arg_seq_err, err_val_err, stable_err, errv_seen;
  bit  res_pend, fbk_pend, res_drop, fbk_drop, arg_drop, err_drop, prev_av, prev_ev;
  int  res_dly, fbk_dly, arg_st, err_st;
  logic [15:0] last_res, cur_tgt, prev_ad, prev_ed, exp_e;

  function automatic int rnd();
    return (max_st == 0) ? 0 : int'($urandom_range(max_st, 0));
  endfunction

  task automatic model_reset();
    w0 = 0; w1 = 0; bias = 0;
    arg_cnt = 0; res_cnt = 0; err_cnt = 0; fbk_cnt = 0; en0_cnt = 0;
    arg_seq_err = 0; err_val_err = 0; stable_err = 0; errv_seen = 0;
  endtask

  // Handshake decisions are made on the falling edge; a transfer seen here completes at the next rising edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst) begin
        arg_ready = 0; res_valid = 0; err_ready = 0; fbk_valid = 0;
        res_pend = 0; fbk_pend = 0; res_drop = 0; fbk_drop = 0; arg_drop = 0; err_drop = 0;
        prev_av = 0; prev_ev = 0;
      end else begin
        if (prev_av && av_m && ad_m != prev_ad) stable_err++;
        if (prev_ev && ev_m && ed_m != prev_ed) stable_err++;
        if (ev_m) errv_seen++;

        if (fbk_drop) begin fbk_valid = 0; fbk_drop = 0; end
        if (fbk_pend && !fbk_valid) begin
          if (fbk_dly > 0) fbk_dly--;
          else begin fbk_valid = 1; fbk_data = $urandom; fbk_pend = 0; end
        end
        if (fbk_valid && fr_m) begin fbk_cnt++; fbk_drop = 1; end

        if (err_drop) begin err_ready = 0; err_drop = 0; end
        if (ev_m && !err_ready && !err_hold) begin
          if (err_st > 0) err_st--; else err_ready = 1;
        end
        if (ev_m && err_ready) begin
          exp_e = cur_tgt - (last_res[15] ? 16'h0000 : 16'h00ff);
          if (ed_m != exp_e) err_val_err++;
          if ($signed(exp_e) > 0) begin w0 += x0; w1 += x1; bias += 1; end
          else if ($signed(exp_e) < 0) begin w0 -= x0; w1 -= x1; bias -= 1; end
          err_cnt++; err_drop = 1; err_st = rnd();
          fbk_pend = 1; fbk_dly = rnd();
        end

        if (res_drop) begin res_valid = 0; res_drop = 0; end
        if (res_pend && !res_valid) begin
          if (res_dly > 0) res_dly--;
          else begin
            res_valid = 1;
            res_data  = res_neg ? 16'hffff : 16'(w0 * x0 + w1 * x1 + bias);
            last_res  = res_data;
            res_pend  = 0;
          end
        end
        if (res_valid && rr_m) begin res_cnt++; res_drop = 1; end

        if (arg_drop) begin arg_ready = 0; arg_drop = 0; end
        if (av_m && !arg_ready) begin
          if (arg_st > 0) arg_st--; else arg_ready = 1;
        end
        if (av_m && arg_ready) begin
          if (ad_m != tb_arg[arg_cnt % S]) arg_seq_err++;
          cur_tgt = tb_tgt[arg_cnt % S];
          x0 = (ad_m[7:0] != 8'h00) ? 1 : 0;
          x1 = (ad_m[15:8] != 8'h00) ? 1 : 0;
          if (!en_m) en0_cnt++;
          arg_cnt++; arg_drop = 1; arg_st = rnd();
          res_pend = 1; res_dly = rnd();
        end

        prev_av = av_m && !arg_ready; prev_ad = ad_m;
        prev_ev = ev_m && !err_ready; prev_ed = ed_m;
      end
    end
  end

  task automatic load(input int a, input logic [15:0] arg, input logic [15:0] tgt, input bit track);
    @(negedge clk);
    ld_en = 1; ld_addr = 2'(a); ld_arg = arg; ld_tgt = tgt;
    if (track) begin tb_arg[a] = arg; tb_tgt[a] = tgt; end
    @(negedge clk);
    ld_en = 0;
  endtask

  task automatic load_table(input logic [15:0] t0, input logic [15:0] t1,
                            input logic [15:0] t2, input logic [15:0] t3);
    load(0, 16'h0000, t0, 1'b1);
    load(1, 16'h00ff, t1, 1'b1);
    load(2, 16'hff00, t2, 1'b1);
    load(3, 16'hffff, t3, 1'b1);
  endtask

  task automatic kick();
    @(negedge clk);
    model_reset();
    if (sel) start1 = 1; else start0 = 1;
    @(negedge clk);
    start1 = 0; start0 = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done_m; i++) @(negedge clk);
    chk(tag, done_m, 1);
  endtask

  task automatic results(input string p, input bit e_pass, input int e_mm, input int e_err,
                         input int e_arg, input int e_en0);
    chk({p, "_pass"}, pass_m, e_pass);
    chk({p, "_mism"}, mm_m, e_mm);
    chk({p, "_busy"}, busy_m, 0);
    chk({p, "_errs"}, err_cnt, e_err);
    chk({p, "_fbks"}, fbk_cnt, e_err);
    chk({p, "_args"}, arg_cnt, e_arg);
    chk({p, "_ress"}, res_cnt, e_arg);
    chk({p, "_en0"}, en0_cnt, e_en0);
    chk({p, "_argseq"}, arg_seq_err, 0);
    chk({p, "_errval"}, err_val_err, 0);
    chk({p, "_stable"}, stable_err, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_en", en1, 0);
    chk("rst_vld_rdy", {av1, rr1, ev1, fr1}, 0);
    chk("rst_mism", mm1, 0);
    chk("rst_data", {ad1, ed1}, 0);
    chk("rst_dut0_busy", busy0, 0);
    rst = 1;

    // 1: AND table, associate always ready
    load_table(16'h0000, 16'h0000, 16'h0000, 16'h00ff);
    sel = 1; max_st = 0;
    kick();
    chk("t1_busy_run", busy1, 1);
    chk("t1_en_run", en1, 1);
    chk("t1_done_run", done1, 0);
    wait_done("t1_done", 3000);
    results("t1", 1'b1, 0, 100, 104, 4);

    // 2: OR table after reset
    @(negedge clk); rst = 0;
    @(negedge clk);
    chk("t2_rst_done", done1, 0);
    rst = 1;
    load_table(16'h0000, 16'h00ff, 16'h00ff, 16'h00ff);
    kick();
    wait_done("t2_done", 3000);
    results("t2", 1'b1, 0, 100, 104, 4);

    // 3: evaluate only, negative responses, entry 0 loaded in the start cycle
    sel = 0; res_neg = 1;
    load(1, 16'h00ff, 16'h00ff, 1'b1);
    load(2, 16'hff00, 16'h00ff, 1'b1);
    load(3, 16'hffff, 16'h00ff, 1'b1);
    @(negedge clk);
    model_reset();
    ld_en = 1; ld_addr = 2'd0; ld_arg = 16'h1234; ld_tgt = 16'h00ff;
    tb_arg[0] = 16'h1234; tb_tgt[0] = 16'h00ff;
    start0 = 1;
    @(negedge clk);
    ld_en = 0; start0 = 0;
    wait_done("t3_done", 500);
    results("t3", 1'b0, 4, 0, 4, 4);
    chk("t3_errv_seen", errv_seen, 0);
    res_neg = 0; sel = 1;

    // 4: random stalls on every channel
    load_table(16'h0000, 16'h0000, 16'h0000, 16'h00ff);
    max_st = 5;
    kick();
    wait_done("t4_done", 8000);
    results("t4", 1'b1, 0, 100, 104, 4);

    // 5: reset while an err transfer is pending
    max_st = 0; err_hold = 1;
    kick();
    for (int i = 0; i < 50 && !ev1; i++) @(negedge clk);
    chk("t5_errv_before", ev1, 1);
    rst = 0;
    #1;
    chk("t5_errv_rst", ev1, 0);
    chk("t5_busy_rst", busy1, 0);
    chk("t5_done_rst", done1, 0);
    repeat (2) @(negedge clk);
    rst = 1; err_hold = 0;
    kick();
    wait_done("t5_done", 3000);
    results("t5", 1'b1, 0, 100, 104, 4);

    // 6: start and table write while busy are ignored
    kick();
    repeat (10) @(negedge clk);
    start1 = 1; ld_en = 1; ld_addr = 2'd0; ld_arg = 16'h5a5a; ld_tgt = 16'h00ff;
    @(negedge clk);
    start1 = 0; ld_en = 0;
    wait_done("t6_done", 3000);
    results("t6", 1'b1, 0, 100, 104, 4);
    repeat (3) @(negedge clk);
    chk("t6_done_hold", done1, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
